// File: rtl/alu_sequencer.sv
// alu_sequencer: sequencing stage of the ALU datapath.
// Accepts one R-type operation per handshake, drives the shared operand bus
// feeding the external combinational ALU and SLL shifter, captures the
// selected result, runs MULTU as a 32-step shift-add into HI/LO, and presents
// one result per operation downstream with backpressure.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [5:0]  op_signal,
  input  logic [31:0] alu_result,
  input  logic [31:0] shift_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam logic [5:0] FUNCT_AND   = 6'd36;
  localparam logic [5:0] FUNCT_OR    = 6'd37;
  localparam logic [5:0] FUNCT_ADD   = 6'd32;
  localparam logic [5:0] FUNCT_SUB   = 6'd34;
  localparam logic [5:0] FUNCT_SLT   = 6'd42;
  localparam logic [5:0] FUNCT_SLL   = 6'd0;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

  localparam logic [4:0] MUL_LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } seqState_t;

  seqState_t   state;
  seqState_t   nextState;

  logic        accept;
  logic        acceptMul;
  logic        mulLast;

  logic [63:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic [63:0] productNext;
  logic [4:0]  mulCount;

  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] execResult;

  // Result selection for a single-cycle operation. Codes outside the
  // supported set produce zero rather than whatever the ALU happens to drive.
  function automatic logic [31:0] selectResult(
    input logic [5:0]  funct,
    input logic [31:0] aluValue,
    input logic [31:0] shiftValue,
    input logic [31:0] hiValue,
    input logic [31:0] loValue
  );
    logic [31:0] result;
    case (funct)
      FUNCT_AND,
      FUNCT_OR,
      FUNCT_ADD,
      FUNCT_SUB,
      FUNCT_SLT:  result = aluValue;
      FUNCT_SLL:  result = shiftValue;
      FUNCT_MFHI: result = hiValue;
      FUNCT_MFLO: result = loValue;
      default:    result = 32'h0;
    endcase
    return result;
  endfunction

  // One shift-add step: conditionally accumulate the current multiplicand.
  function automatic logic [63:0] mulStep(
    input logic [63:0] acc,
    input logic [63:0] addend,
    input logic        takeBit
  );
    return takeBit ? (acc + addend) : acc;
  endfunction

  // Handshake and control decode. Only IDLE can take an operation, so a
  // result leaving DONE can never coincide with a new accept.
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && (state == IDLE);
  assign acceptMul   = accept && (in_funct == FUNCT_MULTU);
  assign mulLast     = (state == MUL) && (mulCount == MUL_LAST_STEP);
  assign productNext = mulStep(product, multiplicand, multiplier[0]);
  assign execResult  = selectResult(op_signal, alu_result, shift_result, hiReg, loReg);

  // State register; reset wins over any handshake activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          nextState = (in_funct == FUNCT_MULTU) ? MUL : EXEC;
        end
      end
      EXEC: begin
        nextState = DONE;
      end
      MUL: begin
        if (mulCount == MUL_LAST_STEP) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // --- stage 0: operand bus, loaded only on the accept cycle ---
  // Operand bus register; holds the last accepted operation in every other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      op_signal <= 6'h0;
    end else if (accept) begin
      op_a      <= in_a;
      op_b      <= in_b;
      op_signal <= in_funct;
    end
  end

  // --- stage 1: shift-add multiplier, one iteration per MUL cycle ---
  // Multiplier datapath: seeded on a MULTU accept, stepped while in MUL.
  always_ff @(posedge clk) begin
    if (reset) begin
      multiplicand <= 64'h0;
      multiplier   <= 32'h0;
      product      <= 64'h0;
      mulCount     <= 5'h0;
    end else if (acceptMul) begin
      multiplicand <= {32'h0, in_a};
      multiplier   <= in_b;
      product      <= 64'h0;
      mulCount     <= 5'h0;
    end else if (state == MUL) begin
      multiplicand <= {multiplicand[62:0], 1'b0};
      multiplier   <= {1'b0, multiplier[31:1]};
      product      <= productNext;
      mulCount     <= mulCount + 5'd1;
    end
  end

  // HI/LO take the full product only on the final multiply step.
  always_ff @(posedge clk) begin
    if (reset) begin
      hiReg <= 32'h0;
      loReg <= 32'h0;
    end else if (mulLast) begin
      hiReg <= productNext[63:32];
      loReg <= productNext[31:0];
    end
  end

  // --- stage 2: result register, stable for the whole DONE phase ---
  // Result capture: EXEC selects the operation result, MULTU completion
  // leaves a zero token; nothing else touches it, so DONE holds it stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= 32'h0;
    end else if (state == EXEC) begin
      out_data <= execResult;
    end else if (mulLast) begin
      out_data <= 32'h0;
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencing stage of the ALU datapath: accepts one R-type operation (funct code plus two 32-bit operands) through a valid/ready handshake and registers the operands and funct onto the shared operand bus. That bus feeds the combinational ALU and the SLL shifter. The stage captures the selected result and runs MULTU as a 32-cycle shift-add into internal HI/LO registers. It presents one result per operation downstream with backpressure.

## Interface
Parameters: none. All widths are fixed.

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept; high only in IDLE
- in_funct  in  6  operation code
- in_a  in  32  operand A
- in_b  in  32  operand B (shift amount for SLL)
- op_a  out  32  registered operand A to ALU and shifter dataA
- op_b  out  32  registered operand B to ALU and shifter dataB
- op_signal  out  6  registered funct to ALU and shifter Signal
- alu_result  in  32  combinational ALU output for op_a/op_b/op_signal
- shift_result  in  32  combinational shifter output
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  32  result

## Operation
- Funct codes:
  - AND 6'd36
  - OR 6'd37
  - ADD 6'd32
  - SUB 6'd34
  - SLT 6'd42
  - SLL 6'd0
  - MULTU 6'd25
  - MFHI 6'd16
  - MFLO 6'd18
- The FSM has four states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - On in_valid & in_ready, latch in_funct/in_a/in_b into op_signal/op_a/op_b.
  - Next state is MUL if funct = MULTU, otherwise EXEC.
- EXEC (exactly 1 cycle): out_data is loaded by funct:
  - AND/OR/ADD/SUB/SLT → alu_result
  - SLL → shift_result
  - MFHI → HI
  - MFLO → LO
  - any other code → 32'h0
  - Next state is DONE.
- SLL contract: the shifter returns 0 when op_b[31:5] ≠ 0. This stage passes shift_result unmodified; it does no range check of its own.
- MUL, setup on entry:
  - 64-bit multiplicand = {32'b0, op_a}
  - 32-bit multiplier = op_b
  - 64-bit product = 0
  - 5-bit counter = 0
- MUL, each cycle:
  - If multiplier[0], add multiplicand to product.
  - Shift multiplicand left 1 and multiplier right 1.
  - Increment the counter.
- MUL, completion: after the 32nd iteration, {HI,LO} ← product (unsigned, no overflow is possible), out_data ← 32'h0 as a completion token, and next state is DONE.
- DONE:
  - out_valid = 1; out_data is held stable.
  - Return to IDLE on out_ready.
  - The stage never accepts a new operation in the same cycle a result is taken.
- op_a/op_b/op_signal hold their last latched values in every state other than the accept cycle.
- HI/LO change only at MULTU completion and on reset.

## Timing
- Reset values:
  - state IDLE, in_ready 1
  - op_a 0, op_b 0, op_signal 0
  - out_valid 0, out_data 0
  - HI 0, LO 0
  - multiplier datapath 0
- Accept at edge T:
  - Operands are valid on the bus during T+1 (EXEC).
  - For non-MULTU operations, out_valid is asserted from T+2.
- MULTU: MUL occupies T+1..T+32; out_valid is asserted from T+33.
- Minimum spacing between accepts is 3 cycles for non-MULTU and 34 cycles for MULTU, with out_ready held high.
- in_ready is combinational from state (state == IDLE). in_valid has no effect outside IDLE.
- out_valid falls the cycle after out_valid & out_ready.
- MFHI/MFLO issued immediately after MULTU completion observe the new HI/LO.
- Reset mid-operation (any state):
  - Next cycle is IDLE with in_ready 1 and out_valid 0.
  - The in-flight operation is discarded with no output.
  - HI/LO are cleared.
- Reset dominates a simultaneous in_valid or out_ready.

## Test plan
- Reset, then SLL with a=32'h0000_0001, b=5 → during EXEC op_signal=0 and op_b=5; out_valid at T+2 with out_data=32'h0000_0020.
- SLL with a=32'hFFFF_FFFF, b=32 → out_data=32'h0 (from the shifter); ADD 7+8 → 32'd15; unknown funct 6'h3F → 32'h0.
- MULTU a=b=32'hFFFF_FFFF → out_valid exactly at T+33 with out_data 0; then MFHI → 32'hFFFF_FFFE and MFLO → 32'h0000_0001.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid and out_data hold, in_ready stays 0, and a concurrent in_valid is not accepted; on the out_ready pulse, IDLE follows the next cycle.
- Reset asserted at MUL cycle 10 of MULTU 3×5 → next cycle IDLE with out_valid 0 and no result emitted; a following MFLO returns 32'h0.
- Back-to-back ops with out_ready tied high: ADD then SUB 5−9 → accepts exactly 3 cycles apart; results are 32'd15 then 32'hFFFF_FFFC.
